mem_port_arbiter: RTL

- Shares the single external memory port between the fetch stage (instruction reads) and the memory-access stage (loads/stores).
- Sits between the fetch and memory-access stages and the external RAM interface.
- Produces the fetch_done and mem_done handshakes that the pipeline controller consumes.
- Decides grants, holds the port for one transaction at a time, and absorbs flushed fetches whose external access cannot be cancelled.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_arb_watchdog.sv | 36 +++
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encodings, the default
// ack timeout and the grant tie-break rule.
package mem_port_arbiter_pkg;

   localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

   typedef enum logic [2:0] {
      ARB_IDLE     = 3'd0,
      ARB_IF_BUSY  = 3'd1,
      ARB_MEM_BUSY = 3'd2,
      ARB_IF_DRAIN = 3'd3,
      ARB_DONE     = 3'd4
   } arb_state_e;

   // Memory access wins unless fetch is also valid and memory won last time.
   function automatic logic pick_mem(input logic mem_v, input logic if_v, input logic last_mem);
      return mem_v && (!if_v || !last_mem);
   endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Ack watchdog for the memory port arbiter. Present only when
// MEM_ARB_TIMEOUT_EN is defined. expired_c fires in the cycle the count of
// unacknowledged request cycles reaches TIMEOUT_CYCLES.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired_c
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Clear on grant, count each cycle waiting for ack.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)         cnt_d = '0;
      else if (count_en) cnt_d = cnt_q + CNT_W'(1);
   end

   assign expired_c = count_en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one external memory port between instruction fetch and the
// load/store stage. One transaction at a time; flushed fetches are drained.
// Optional ack timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   input  logic                    if_flush,
   output logic                    if_done,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    mem_req,
   input  logic                    mem_we,
   input  logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH/8-1:0] mem_be,
   output logic                    mem_done,
   output logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    ext_req,
   output logic                    ext_we,
   output logic [ADDR_WIDTH-1:0]   ext_addr,
   output logic [DATA_WIDTH-1:0]   ext_wdata,
   output logic [DATA_WIDTH/8-1:0] ext_be,
   input  logic                    ext_ack,
   input  logic [DATA_WIDTH-1:0]   ext_rdata,
   output logic                    port_idle,
   output logic                    bus_error
);
   localparam int unsigned BE_W = DATA_WIDTH / 8;

   arb_state_e            state_q, state_d;
   logic                  last_mem_q, last_mem_d;
   logic                  ext_req_q, ext_req_d;
   logic                  ext_we_q, ext_we_d;
   logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
   logic [DATA_WIDTH-1:0] ext_wdata_q, ext_wdata_d;
   logic [BE_W-1:0]       ext_be_q, ext_be_d;
   logic                  if_done_q, if_done_d;
   logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
   logic                  mem_done_q, mem_done_d;
   logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
   logic                  port_idle_q, port_idle_d;
   logic                  bus_error_q, bus_error_d;

   logic if_valid, grant_mem, grant_if, timeout_c, finish_c;

   assign if_valid  = if_req && !if_flush;
   assign grant_mem = pick_mem(mem_req, if_valid, last_mem_q);
   assign grant_if  = if_valid && !grant_mem;
   assign finish_c  = ext_ack || timeout_c;

`ifdef MEM_ARB_TIMEOUT_EN
   logic wd_clear, wd_count;
   assign wd_clear = (state_q == ARB_IDLE) && (grant_mem || grant_if);
   assign wd_count = ext_req_q && !ext_ack;

   mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear     (wd_clear),
      .count_en  (wd_count),
      .expired_c (timeout_c)
   );
`else
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] unused_timeout;
   assign unused_timeout = TO_W'(TIMEOUT_CYCLES);
   assign timeout_c      = 1'b0;
`endif

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         last_mem_q  <= 1'b0;
         ext_req_q   <= 1'b0;
         ext_we_q    <= 1'b0;
         ext_addr_q  <= '0;
         ext_wdata_q <= '0;
         ext_be_q    <= '0;
         if_done_q   <= 1'b0;
         if_rdata_q  <= '0;
         mem_done_q  <= 1'b0;
         mem_rdata_q <= '0;
         port_idle_q <= 1'b1;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_mem_q  <= last_mem_d;
         ext_req_q   <= ext_req_d;
         ext_we_q    <= ext_we_d;
         ext_addr_q  <= ext_addr_d;
         ext_wdata_q <= ext_wdata_d;
         ext_be_q    <= ext_be_d;
         if_done_q   <= if_done_d;
         if_rdata_q  <= if_rdata_d;
         mem_done_q  <= mem_done_d;
         mem_rdata_q <= mem_rdata_d;
         port_idle_q <= port_idle_d;
         bus_error_q <= bus_error_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_mem)     state_d = ARB_MEM_BUSY;
            else if (grant_if) state_d = ARB_IF_BUSY;
         end
         ARB_IF_BUSY: begin
            if (finish_c)      state_d = ARB_DONE;
            else if (if_flush) state_d = ARB_IF_DRAIN;
         end
         ARB_IF_DRAIN,
         ARB_MEM_BUSY: begin
            if (finish_c) state_d = ARB_DONE;
         end
         ARB_DONE: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   // Grant latching, ext request handshake and done/rdata generation.
   always_comb begin
      last_mem_d  = last_mem_q;
      ext_req_d   = ext_req_q;
      ext_we_d    = ext_we_q;
      ext_addr_d  = ext_addr_q;
      ext_wdata_d = ext_wdata_q;
      ext_be_d    = ext_be_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      bus_error_d = 1'b0;
      port_idle_d = (state_d == ARB_IDLE);
      case (state_q)
         ARB_IDLE: begin
            if (grant_mem) begin
               ext_req_d   = 1'b1;
               ext_we_d    = mem_we;
               ext_addr_d  = mem_addr;
               ext_wdata_d = mem_wdata;
               ext_be_d    = mem_be;
               last_mem_d  = 1'b1;
            end else if (grant_if) begin
               ext_req_d   = 1'b1;
               ext_we_d    = 1'b0;
               ext_addr_d  = if_addr;
               ext_wdata_d = '0;
               ext_be_d    = '1;
               last_mem_d  = 1'b0;
            end
         end
         ARB_IF_BUSY: begin
            if (finish_c) begin
               ext_req_d   = 1'b0;
               bus_error_d = timeout_c;
               // A flush in the completing cycle still discards the fetch.
               if (!if_flush) begin
                  if_done_d  = 1'b1;
                  if_rdata_d = timeout_c ? '0 : ext_rdata;
               end
            end
         end
         ARB_IF_DRAIN: begin
            if (finish_c) begin
               ext_req_d   = 1'b0;
               bus_error_d = timeout_c;
            end
         end
         ARB_MEM_BUSY: begin
            if (finish_c) begin
               ext_req_d   = 1'b0;
               bus_error_d = timeout_c;
               mem_done_d  = 1'b1;
               if (timeout_c)     mem_rdata_d = '0;
               else if (!ext_we_q) mem_rdata_d = ext_rdata;
            end
         end
         default: ;
      endcase
   end

   assign ext_req   = ext_req_q;
   assign ext_we    = ext_we_q;
   assign ext_addr  = ext_addr_q;
   assign ext_wdata = ext_wdata_q;
   assign ext_be    = ext_be_q;
   assign if_done   = if_done_q;
   assign if_rdata  = if_rdata_q;
   assign mem_done  = mem_done_q;
   assign mem_rdata = mem_rdata_q;
   assign port_idle = port_idle_q;
   assign bus_error = bus_error_q;

endmodule
